// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction memory.
// Takes a byte stream over a valid/ready handshake and builds big-endian 32-bit words.
// The stream is: header word N, then N payload words, then an XOR checksum word.
// Payload words are written to byte addresses 0,4,8,...
// The processor is held in reset until the image is loaded and the checksum matches.
// Ports:
//   CLK, Reset     clock (rising edge), asynchronous active-low reset
//   Start          1-cycle restart pulse, honoured only in DONE or ERR
//   Byte_Valid/Byte_Data/Byte_Ready   byte stream handshake (transfer = Valid & Ready)
//   IM_WE/IM_A/IM_WD                  instruction memory write port
//   Cpu_Hold       1 = keep the processor in reset
//   Done, Error    load finished and verified / length overflow or checksum mismatch
module imem_loader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 256
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Byte_Valid,
    input  logic [7:0]            Byte_Data,
    output logic                  Byte_Ready,
    output logic                  IM_WE,
    output logic [ADDR_WIDTH-1:0] IM_A,
    output logic [DATA_WIDTH-1:0] IM_WD,
    output logic                  Cpu_Hold,
    output logic                  Done,
    output logic                  Error
);

    // word_idx and N must both be able to hold MEM_DEPTH itself
    localparam int unsigned IdxW = $clog2(MEM_DEPTH + 1);

    typedef enum logic [2:0] {StHdr, StData, StWr, StCsum, StDone, StErr} state_e;

    state_e                state_q, state_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [DATA_WIDTH-9:0] shreg_q, shreg_d;
    logic [IdxW-1:0]       n_q, n_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [DATA_WIDTH-1:0] csum_q, csum_d;
    logic [DATA_WIDTH-1:0] wd_q, wd_d;
    logic [ADDR_WIDTH-1:0] a_q, a_d;
    // Keeps Byte_Ready low until the first clock after reset release
    logic                  ready_en_q;

    logic                  xfer;
    logic                  word_done;
    logic [DATA_WIDTH-1:0] word;

    assign xfer      = Byte_Valid & Byte_Ready;
    assign word_done = xfer && (byte_cnt_q == 2'd3);
    assign word      = {shreg_q, Byte_Data};

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q    <= StHdr;
            byte_cnt_q <= 2'd0;
            shreg_q    <= '0;
            n_q        <= '0;
            idx_q      <= '0;
            csum_q     <= '0;
            wd_q       <= '0;
            a_q        <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            shreg_q    <= shreg_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            csum_q     <= csum_d;
            wd_q       <= wd_d;
            a_q        <= a_d;
            ready_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shreg_d    = shreg_q;
        n_d        = n_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        wd_d       = wd_q;
        a_d        = a_q;

        // Partial words survive stalls: only a real transfer moves the assembler
        if (xfer) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            shreg_d    = word[DATA_WIDTH-9:0];
        end

        unique case (state_q)
            StHdr: begin
                if (word_done) begin
                    if (word > DATA_WIDTH'(MEM_DEPTH)) begin
                        state_d = StErr;
                    end else begin
                        n_d     = IdxW'(word);
                        state_d = (word == '0) ? StCsum : StData;
                    end
                end
            end
            StData: begin
                if (word_done) begin
                    wd_d    = word;
                    a_d     = ADDR_WIDTH'(idx_q) << 2;
                    state_d = StWr;
                end
            end
            StWr: begin
                csum_d  = csum_q ^ wd_q;
                idx_d   = idx_q + IdxW'(1);
                state_d = (idx_d == n_q) ? StCsum : StData;
            end
            StCsum: begin
                if (word_done) begin
                    state_d = (word == csum_q) ? StDone : StErr;
                end
            end
            StDone, StErr: begin
                if (Start) begin
                    state_d    = StHdr;
                    byte_cnt_d = 2'd0;
                    idx_d      = '0;
                    csum_d     = '0;
                end
            end
            default: state_d = StHdr;
        endcase
    end

    always_comb begin
        Byte_Ready = ready_en_q &&
                     ((state_q == StHdr) || (state_q == StData) || (state_q == StCsum));
        IM_WE      = (state_q == StWr);
        IM_A       = a_q;
        IM_WD      = wd_q;
        Cpu_Hold   = (state_q != StDone);
        Done       = (state_q == StDone);
        Error      = (state_q == StErr);
    end

endmodule
